// File: rtl/alu_wide_sequencer.sv
// Purpose : steps the 8-bit ALU through 1..MAX_BYTES byte operations and merges per-byte flags.
// Latency : accept to Done = N*(ALU_LATENCY+1)+1 cycles; a rejected request completes 1 cycle after accept.
// Backpr. : none; Req is sampled only in IDLE and is dropped while Busy (including the Done cycle).
// Ports   : Req/ReqOp/ReqBytes/ReqMsbFirst/ReqCarryIn start an operation; Busy/Done/Err report it;
//           ByteSel steers the GPR byte muxes; Pipe1Out_*_ALUOP*, Alu_Assert, LCarryIn drive the ALU;
//           ResultWe writes result byte ByteSel; Flags_* are per-byte ALU flags, WideFlags the merge.
module alu_wide_sequencer #(
  parameter int MAX_BYTES   = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Req,
  input  logic [3:0] ReqOp,
  input  logic [2:0] ReqBytes,
  input  logic       ReqMsbFirst,
  input  logic       ReqCarryIn,
  output logic       Busy,
  output logic       Done,
  output logic       Err,
  output logic [2:0] ByteSel,
  output logic       Pipe1Out_4_ALUOP0,
  output logic       Pipe1Out_5_ALUOP1,
  output logic       Pipe1Out_6_ALUOP2,
  output logic       Pipe1Out_7_ALUOP3,
  output logic       Alu_Assert,
  output logic       ResultWe,
  output logic       LCarryIn,
  input  logic       Flags_0_Overflow,
  input  logic       Flags_1_Sign,
  input  logic       Flags_2_Zero,
  input  logic       Flags_3_CarryA,
  input  logic       Flags_4_CarryL,
  output logic [4:0] WideFlags
);

  // WAIT lasts ALU_LATENCY-1 cycles: the counter is loaded with ALU_LATENCY-2 and exits at zero.
  localparam int              CW        = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0]   WAIT_LOAD = CW'((ALU_LATENCY > 1) ? ALU_LATENCY - 2 : 0);
  localparam logic [2:0]      MAX_B     = 3'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_FIN
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [2:0]    bytes_q;
  logic          msb_q;
  logic          err_q;
  logic [2:0]    byte_sel_q;
  logic          lcarry_q;
  logic [CW-1:0] wait_cnt;
  logic [4:0]    acc_flags;
  logic [4:0]    wide_q;
  logic          op_drive;
  logic          bad_req;
  logic          last_byte;
  logic          msb_byte;
  logic [4:0]    merged;

  assign bad_req   = (ReqBytes == 3'd0) || (ReqBytes > MAX_B);
  assign last_byte = msb_q ? (byte_sel_q == 3'd0) : (byte_sel_q == bytes_q - 3'd1);
  assign msb_byte  = (byte_sel_q == bytes_q - 3'd1);

  // Flag order {CarryL, CarryA, Zero, Sign, Overflow}. Zero is an AND across bytes, carries follow
  // the byte just processed, Sign/Overflow are only taken from the most significant byte.
  assign merged = {Flags_4_CarryL,
                   Flags_3_CarryA,
                   acc_flags[2] & Flags_2_Zero,
                   msb_byte ? Flags_1_Sign     : acc_flags[1],
                   msb_byte ? Flags_0_Overflow : acc_flags[0]};

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    op_drive   = 1'b0;
    Alu_Assert = 1'b1;
    ResultWe   = 1'b0;
    Done       = 1'b0;
    Err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (Req) begin
          state_nxt = bad_req ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        op_drive  = 1'b1;
        state_nxt = (ALU_LATENCY == 1) ? S_CAPTURE : S_WAIT;
      end
      S_WAIT: begin
        op_drive = 1'b1;
        if (wait_cnt == '0) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        op_drive   = 1'b1;
        Alu_Assert = 1'b0;
        ResultWe   = 1'b1;
        state_nxt  = last_byte ? S_FIN : S_ISSUE;
      end
      S_FIN: begin
        Done      = 1'b1;
        Err       = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      op_q       <= 4'd0;
      bytes_q    <= 3'd0;
      msb_q      <= 1'b0;
      err_q      <= 1'b0;
      byte_sel_q <= 3'd0;
      lcarry_q   <= 1'b0;
      wait_cnt   <= '0;
      acc_flags  <= 5'd0;
      wide_q     <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req) begin
            op_q      <= ReqOp;
            bytes_q   <= ReqBytes;
            msb_q     <= ReqMsbFirst;
            err_q     <= bad_req;
            lcarry_q  <= ReqCarryIn;
            acc_flags <= 5'b00100;
            // A rejected width may be 0, so never form ReqBytes-1 for it.
            byte_sel_q <= (bad_req || !ReqMsbFirst) ? 3'd0 : ReqBytes - 3'd1;
          end
        end
        S_ISSUE: begin
          wait_cnt <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_CAPTURE: begin
          lcarry_q  <= Flags_4_CarryL;
          acc_flags <= merged;
          if (last_byte) begin
            wide_q <= merged;
          end else begin
            byte_sel_q <= msb_q ? byte_sel_q - 3'd1 : byte_sel_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state != S_IDLE);
  assign ByteSel   = byte_sel_q;
  assign LCarryIn  = lcarry_q;
  assign WideFlags = wide_q;
  assign {Pipe1Out_7_ALUOP3, Pipe1Out_6_ALUOP2, Pipe1Out_5_ALUOP1, Pipe1Out_4_ALUOP0} =
         op_drive ? op_q : 4'd0;

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Purpose : self-checking bench for alu_wide_sequencer with a completion scoreboard.
// Latency : expected accept-to-Done latency is carried in the scoreboard per request.
// Backpr. : none; requests are only issued when the sequencer is idle, except deliberate ignored pulses.
module tb_alu_wide_sequencer;
  localparam int MAXB = 4;
  localparam int LAT  = 1;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Req = 1'b0;
  logic [3:0] ReqOp = 4'd0;
  logic [2:0] ReqBytes = 3'd0;
  logic       ReqMsbFirst = 1'b0;
  logic       ReqCarryIn = 1'b0;
  logic       Busy, Done, Err, Alu_Assert, ResultWe, LCarryIn;
  logic [2:0] ByteSel;
  logic       Pipe1Out_4_ALUOP0, Pipe1Out_5_ALUOP1, Pipe1Out_6_ALUOP2, Pipe1Out_7_ALUOP3;
  logic       Flags_0_Overflow, Flags_1_Sign, Flags_2_Zero, Flags_3_CarryA, Flags_4_CarryL;
  logic [4:0] WideFlags;
  logic [3:0] opbits;

  // Per-byte flag table {CarryL, CarryA, Zero, Sign, Overflow}, indexed by the byte the DUT presents.
  logic [4:0] ftbl [0:7];
  assign {Flags_4_CarryL, Flags_3_CarryA, Flags_2_Zero, Flags_1_Sign, Flags_0_Overflow} = ftbl[ByteSel];
  assign opbits = {Pipe1Out_7_ALUOP3, Pipe1Out_6_ALUOP2, Pipe1Out_5_ALUOP1, Pipe1Out_4_ALUOP0};

  alu_wide_sequencer #(.MAX_BYTES(MAXB), .ALU_LATENCY(LAT)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .ReqOp(ReqOp), .ReqBytes(ReqBytes),
    .ReqMsbFirst(ReqMsbFirst), .ReqCarryIn(ReqCarryIn), .Busy(Busy), .Done(Done), .Err(Err),
    .ByteSel(ByteSel), .Pipe1Out_4_ALUOP0(Pipe1Out_4_ALUOP0), .Pipe1Out_5_ALUOP1(Pipe1Out_5_ALUOP1),
    .Pipe1Out_6_ALUOP2(Pipe1Out_6_ALUOP2), .Pipe1Out_7_ALUOP3(Pipe1Out_7_ALUOP3),
    .Alu_Assert(Alu_Assert), .ResultWe(ResultWe), .LCarryIn(LCarryIn),
    .Flags_0_Overflow(Flags_0_Overflow), .Flags_1_Sign(Flags_1_Sign), .Flags_2_Zero(Flags_2_Zero),
    .Flags_3_CarryA(Flags_3_CarryA), .Flags_4_CarryL(Flags_4_CarryL), .WideFlags(WideFlags)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Observed events, recorded just after each rising edge.
  int         done_cyc_q[$];
  logic       done_err_q[$];
  logic [4:0] done_flags_q[$];
  logic [2:0] sel_log[$];
  logic       lc_log[$];
  logic       as_log[$];
  int         we_cyc_q[$];
  int         done_cnt = 0;
  int         we_cnt = 0;
  int         as_low_cnt = 0;

  always @(posedge Clock) begin
    #1;
    if (ResultWe) begin
      sel_log.push_back(ByteSel);
      lc_log.push_back(LCarryIn);
      as_log.push_back(Alu_Assert);
      we_cyc_q.push_back(cyc);
      we_cnt++;
    end
    if (!Alu_Assert) as_low_cnt++;
    if (Done) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(Err);
      done_flags_q.push_back(WideFlags);
      done_cnt++;
    end
  end

  // Scoreboard of expected completions.
  int         sb_req_cyc[$];
  int         sb_lat[$];
  int         sb_n[$];
  logic       sb_err[$];
  logic [4:0] sb_flags[$];
  logic [2:0] exp_sel[$];
  logic       exp_lc[$];
  logic [4:0] last_good = 5'd0;

  // Called at a falling edge; drives a one-cycle request and pushes its expected outcome.
  task automatic start_op(input logic [3:0] op, input logic [2:0] nb, input logic msb, input logic cin);
    int n;
    int idx;
    logic c;
    logic z;
    logic [4:0] f;
    n = int'(nb);
    Req = 1'b1; ReqOp = op; ReqBytes = nb; ReqMsbFirst = msb; ReqCarryIn = cin;
    sb_req_cyc.push_back(cyc);
    if (n == 0 || n > MAXB) begin
      sb_err.push_back(1'b1);
      sb_lat.push_back(1);
      sb_n.push_back(0);
      sb_flags.push_back(last_good);
    end else begin
      c = cin; z = 1'b1; f = 5'd0;
      for (int k = 0; k < n; k++) begin
        idx = msb ? (n - 1 - k) : k;
        exp_sel.push_back(idx[2:0]);
        exp_lc.push_back(c);
        c = ftbl[idx][4];
        z = z & ftbl[idx][2];
        f[4] = ftbl[idx][4];
        f[3] = ftbl[idx][3];
        if (idx == n - 1) begin
          f[1] = ftbl[idx][1];
          f[0] = ftbl[idx][0];
        end
      end
      f[2] = z;
      sb_err.push_back(1'b0);
      sb_lat.push_back(n * (LAT + 1) + 1);
      sb_n.push_back(n);
      sb_flags.push_back(f);
      last_good = f;
    end
    @(negedge Clock);
    Req = 1'b0;
  endtask

  // Pops one expected completion and the matching observed completion and byte log.
  task automatic drain(input string name);
    int t, rc, el, n, dc;
    logic ee, de;
    logic [4:0] ef, df;
    t = 0;
    while (done_cyc_q.size() == 0 && t < 200) begin
      @(negedge Clock);
      t++;
    end
    rc = sb_req_cyc.pop_front(); el = sb_lat.pop_front(); n = sb_n.pop_front();
    ee = sb_err.pop_front(); ef = sb_flags.pop_front();
    total++;
    if (done_cyc_q.size() == 0) begin
      bad++;
      $display("FAIL %s_done: no Done within 200 cycles, expected one", name);
      for (int k = 0; k < n; k++) begin
        void'(exp_sel.pop_front());
        void'(exp_lc.pop_front());
      end
      return;
    end
    dc = done_cyc_q.pop_front(); de = done_err_q.pop_front(); df = done_flags_q.pop_front();
    total++;
    if ((dc - rc) !== el) begin
      bad++; $display("FAIL %s_latency: got %0d expected %0d", name, dc - rc, el);
    end
    total++;
    if (de !== ee) begin
      bad++; $display("FAIL %s_err: got %0b expected %0b", name, de, ee);
    end
    total++;
    if (df !== ef) begin
      bad++; $display("FAIL %s_wideflags: got %05b expected %05b", name, df, ef);
    end
    total++;
    if (sel_log.size() < n) begin
      bad++; $display("FAIL %s_we_count: got %0d expected at least %0d", name, sel_log.size(), n);
      sel_log.delete(); lc_log.delete(); as_log.delete();
      for (int k = 0; k < n; k++) begin
        void'(exp_sel.pop_front());
        void'(exp_lc.pop_front());
      end
      return;
    end
    for (int k = 0; k < n; k++) begin
      logic [2:0] es, os;
      logic       elc, olc, oas;
      es = exp_sel.pop_front(); elc = exp_lc.pop_front();
      os = sel_log.pop_front(); olc = lc_log.pop_front(); oas = as_log.pop_front();
      total++;
      if (os !== es) begin
        bad++; $display("FAIL %s_bytesel[%0d]: got %0d expected %0d", name, k, os, es);
      end
      total++;
      if (olc !== elc) begin
        bad++; $display("FAIL %s_lcarryin[%0d]: got %0b expected %0b", name, k, olc, elc);
      end
      total++;
      if (oas !== 1'b0) begin
        bad++; $display("FAIL %s_alu_assert[%0d]: got %0b expected 0", name, k, oas);
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clock);
    total++;
    if ({Busy, Done, Err, ResultWe} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got busy/done/err/we=%04b expected 0000", {Busy, Done, Err, ResultWe});
    end
    total++;
    if (Alu_Assert !== 1'b1) begin
      bad++; $display("FAIL reset_alu_assert: got %0b expected 1", Alu_Assert);
    end
    total++;
    if ({opbits, ByteSel, LCarryIn, WideFlags} !== 13'd0) begin
      bad++; $display("FAIL reset_data: got op=%0h sel=%0d lc=%0b wf=%05b expected all 0",
                      opbits, ByteSel, LCarryIn, WideFlags);
    end
    Reset_n = 1'b1;
    repeat (2) @(negedge Clock);
  endtask

  task automatic test_add16();
    int busy_bad;
    int t;
    ftbl[0] = 5'b00100;
    ftbl[1] = 5'b01110;
    we_cyc_q.delete();
    start_op(4'h1, 3'd2, 1'b0, 1'b0);
    busy_bad = 0;
    t = 0;
    while (!Done && t < 40) begin
      if (Busy !== 1'b1) busy_bad++;
      @(negedge Clock);
      t++;
    end
    if (Busy !== 1'b1) busy_bad++;
    total++;
    if (busy_bad != 0) begin
      bad++; $display("FAIL add16_busy: got %0d low cycles expected 0", busy_bad);
    end
    @(negedge Clock);
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL add16_busy_after: got %0b expected 0", Busy);
    end
    total++;
    if (we_cyc_q.size() != 2) begin
      bad++; $display("FAIL add16_we_pulses: got %0d expected 2", we_cyc_q.size());
    end else begin
      total++;
      if (we_cyc_q[1] - we_cyc_q[0] != 2) begin
        bad++; $display("FAIL add16_we_spacing: got %0d expected 2", we_cyc_q[1] - we_cyc_q[0]);
      end
    end
    drain("add16");
    total++;
    if (WideFlags[2] !== 1'b1) begin
      bad++; $display("FAIL add16_zero: got %0b expected 1", WideFlags[2]);
    end
  endtask

  task automatic test_shr32();
    ftbl[3] = 5'b00110;
    ftbl[2] = 5'b10100;
    ftbl[1] = 5'b10000;
    ftbl[0] = 5'b01100;
    repeat (2) @(negedge Clock);
    start_op(4'h9, 3'd4, 1'b1, 1'b1);
    drain("shr32");
    total++;
    if (WideFlags[4] !== 1'b0) begin
      bad++; $display("FAIL shr32_carryl: got %0b expected 0", WideFlags[4]);
    end
  endtask

  task automatic test_zero3();
    ftbl[0] = 5'b00100;
    ftbl[1] = 5'b00000;
    ftbl[2] = 5'b00111;
    repeat (2) @(negedge Clock);
    start_op(4'h2, 3'd3, 1'b0, 1'b0);
    drain("zero3");
    total++;
    if ({WideFlags[2], WideFlags[1:0]} !== 3'b011) begin
      bad++; $display("FAIL zero3_zsv: got %03b expected 011", {WideFlags[2], WideFlags[1:0]});
    end
  endtask

  task automatic test_err();
    int we0, as0;
    logic [4:0] wf0;
    logic [2:0] over;
    repeat (2) @(negedge Clock);
    we0 = we_cnt; as0 = as_low_cnt; wf0 = WideFlags;
    over = 3'(MAXB + 1);
    start_op(4'h3, 3'd0, 1'b0, 1'b0);
    drain("err_zero");
    repeat (2) @(negedge Clock);
    start_op(4'h3, over, 1'b1, 1'b0);
    drain("err_over");
    repeat (2) @(negedge Clock);
    total++;
    if (we_cnt != we0) begin
      bad++; $display("FAIL err_result_we: got %0d pulses expected 0", we_cnt - we0);
    end
    total++;
    if (as_low_cnt != as0) begin
      bad++; $display("FAIL err_alu_assert: got %0d low cycles expected 0", as_low_cnt - as0);
    end
    total++;
    if (WideFlags !== wf0) begin
      bad++; $display("FAIL err_wideflags: got %05b expected %05b", WideFlags, wf0);
    end
  endtask

  task automatic test_ignore_req();
    int d0, t;
    repeat (2) @(negedge Clock);
    d0 = done_cnt;
    start_op(4'h4, 3'd3, 1'b0, 1'b0);
    repeat (2) @(negedge Clock);
    Req = 1'b1; ReqBytes = 3'd1;
    @(negedge Clock);
    Req = 1'b0;
    t = 0;
    while (!Done && t < 40) begin
      @(negedge Clock);
      t++;
    end
    Req = 1'b1;
    @(negedge Clock);
    Req = 1'b0;
    repeat (20) @(negedge Clock);
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0);
    end
    total++;
    if (Busy !== 1'b0) begin
      bad++; $display("FAIL ignore_busy: got %0b expected 0", Busy);
    end
    drain("ignore");
  endtask

  task automatic test_reset_mid();
    int k, t, d0, w0;
    repeat (2) @(negedge Clock);
    start_op(4'h1, 3'd4, 1'b0, 1'b0);
    k = 0; t = 0;
    while (k < 2 && t < 40) begin
      if (ResultWe) k++;
      if (k < 2) begin
        @(negedge Clock);
        t++;
      end
    end
    total++;
    if (k != 2) begin
      bad++; $display("FAIL rstmid_capture: got %0d captures expected 2", k);
    end
    Reset_n = 1'b0;
    @(negedge Clock);
    total++;
    if ({Busy, Done, Err, ResultWe, Alu_Assert} !== 5'b00001) begin
      bad++; $display("FAIL rstmid_ctrl: got %05b expected 00001", {Busy, Done, Err, ResultWe, Alu_Assert});
    end
    total++;
    if ({opbits, ByteSel, LCarryIn, WideFlags} !== 13'd0) begin
      bad++; $display("FAIL rstmid_data: got op=%0h sel=%0d lc=%0b wf=%05b expected all 0",
                      opbits, ByteSel, LCarryIn, WideFlags);
    end
    Reset_n = 1'b1;
    void'(sb_req_cyc.pop_back()); void'(sb_lat.pop_back()); void'(sb_n.pop_back());
    void'(sb_err.pop_back()); void'(sb_flags.pop_back());
    exp_sel.delete(); exp_lc.delete(); sel_log.delete(); lc_log.delete(); as_log.delete();
    last_good = 5'd0;
    d0 = done_cnt; w0 = we_cnt;
    repeat (15) @(negedge Clock);
    total++;
    if (done_cnt != d0) begin
      bad++; $display("FAIL rstmid_no_done: got %0d Done pulses expected 0", done_cnt - d0);
    end
    total++;
    if (we_cnt != w0) begin
      bad++; $display("FAIL rstmid_no_we: got %0d ResultWe pulses expected 0", we_cnt - w0);
    end
    start_op(4'h5, 3'd2, 1'b0, 1'b1);
    drain("rstmid_after");
  endtask

  task automatic test_back_to_back();
    int t;
    ftbl[0] = 5'b11101;
    ftbl[1] = 5'b00010;
    repeat (2) @(negedge Clock);
    start_op(4'h6, 3'd1, 1'b0, 1'b0);
    t = 0;
    while (!Done && t < 40) begin
      @(negedge Clock);
      t++;
    end
    @(negedge Clock);
    start_op(4'h7, 3'd2, 1'b1, 1'b1);
    drain("b2b_first");
    drain("b2b_second");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ftbl[i] = 5'd0;
    test_reset();
    test_add16();
    test_shr32();
    test_zero3();
    test_err();
    test_ignore_req();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_wide_sequencer.md
Name: alu_wide_sequencer

Overview:
Sequences the 8-bit ALU through multi-byte (16/24/32-bit) operations. It accepts one wide-operation request, then issues the ALU opcode once per byte and steps a byte index that the GPR file uses to present the LHS/RHS byte. Between bytes it chains the shift carry through LCarryIn and samples the per-byte flags. It merges those into one set of wide-result flags and sits between the instruction decode pipe and the ALU block.

Parameters:
MAX_BYTES, 4, largest operand width in bytes (1..7).
ALU_LATENCY, 1, Clock cycles from opcode issue to valid ALU result/flags (>=1).

Ports:
Clock  input  1  system clock
Reset_n  input  1  reset, synchronous, active-low
Req  input  1  start request, sampled only in IDLE
ReqOp  input  4  ALU opcode for the whole operation
ReqBytes  input  3  operand width in bytes
ReqMsbFirst  input  1  1 = process MSB byte first (right shifts)
ReqCarryIn  input  1  carry into first byte
Busy  output  1  high from accept until Done cycle inclusive
Done  output  1  one-cycle completion pulse
Err  output  1  valid with Done; request rejected
ByteSel  output  3  byte index presented to GPR LHS/RHS muxes
Pipe1Out_4_ALUOP0..Pipe1Out_7_ALUOP3  output  1 each  opcode bits to ALU
Alu_Assert  output  1  active-low ALU MainBus drive
ResultWe  output  1  write strobe for result byte ByteSel
LCarryIn  output  1  shift carry into ALU
Flags_0_Overflow..Flags_4_CarryL  input  1 each  per-byte ALU flags
WideFlags  output  5  merged flags, same bit order as inputs

Behaviour:
- Reset (Reset_n low at a Clock edge) takes precedence over everything.
  - State goes to IDLE.
  - Busy, Done, Err and ResultWe go to 0.
  - Alu_Assert goes to 1, and the opcode outputs, ByteSel, LCarryIn and WideFlags go to 0.
  - Reset mid-operation abandons the operation, with no Done and no further ResultWe.
- States are IDLE, ISSUE, WAIT, CAPTURE and FIN.
- IDLE: Req=1 latches ReqOp, ReqBytes, ReqMsbFirst and ReqCarryIn.
  - ReqBytes==0 or ReqBytes>MAX_BYTES: go to FIN with Err=1 and no ALU activity.
  - Otherwise go to ISSUE with Busy=1.
  - Starting ByteSel is 0, or ReqBytes-1 when MSB-first.
  - LCarryIn is set to the latched ReqCarryIn.
- ISSUE (1 cycle): drive the latched opcode on the ALUOP bits. Go to WAIT, or straight to CAPTURE when ALU_LATENCY==1.
- WAIT: hold the opcode for ALU_LATENCY-1 cycles, then go to CAPTURE.
- CAPTURE (1 cycle):
  - Alu_Assert=0 and ResultWe=1 for the current ByteSel.
  - Sample the flags and register Flags_4_CarryL as the next LCarryIn.
  - Merge flags:
    - Zero accumulates as AND over all bytes; it is seeded with 1.
    - CarryA and CarryL take the last-processed byte.
    - Sign and Overflow take the MSB byte's values, whichever pass processed it.
  - If bytes remain: step ByteSel (+1, or -1 when MSB-first) and go to ISSUE.
  - Otherwise go to FIN.
- FIN (1 cycle): Done=1 and WideFlags updated; Err holds the rejection result. Return to IDLE with Busy=0 on the next cycle.
- Outside CAPTURE: Alu_Assert=1 and ResultWe=0. The opcode outputs are 0 in IDLE and FIN.
- Latency, accept to Done: N*(ALU_LATENCY+1)+1 cycles, where N is the byte count.
- Req while Busy is ignored; it is not queued.
- Req asserted in the same cycle as Done is ignored.
- Back-to-back operations: a new Req is accepted in the first IDLE cycle after FIN.
- WideFlags holds its value until the next successful FIN; an Err completion leaves it unchanged.
- ByteSel never leaves the range 0..ReqBytes-1 and never wraps.

Test Plan:
- 16-bit LSB-first add, ReqBytes=2, ALU_LATENCY=1:
  - ByteSel runs 0 then 1, with ResultWe pulses 2 cycles apart.
  - Done arrives 5 cycles after accept, with Busy high throughout.
  - With per-byte Zero = 1,1, WideFlags Zero=1.
- 32-bit MSB-first shift right, ReqCarryIn=1, CarryL per byte 0,1,1,0:
  - ByteSel runs 3,2,1,0.
  - LCarryIn per issue is 1,0,1,1.
  - WideFlags CarryL=0.
- Per-byte Zero 1,0,1 on a 3-byte op gives WideFlags Zero=0. Sign and Overflow come from byte 2.
- ReqBytes=0 and ReqBytes=MAX_BYTES+1: Done and Err pulse 1 cycle after accept, with no ResultWe, Alu_Assert held at 1, and WideFlags unchanged.
- Req pulsed mid-operation and in the Done cycle: both ignored, with exactly one Done per accepted Req.
- Reset_n low during the second CAPTURE of a 4-byte op:
  - The next cycle shows all outputs at reset values.
  - No Done is produced.
  - A new request afterwards completes normally.
